// File: rtl/orb_rd_arbiter_if.sv
// Read port of the shared word memory: arbiter drives strobe/select/address, memory returns data.
interface orb_rd_arbiter_if;
    logic        mem_rd;
    logic [2:0]  mem_sel;
    logic [10:0] mem_addr;
    logic [11:0] mem_data;

    modport master (output mem_rd, output mem_sel, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_sel, input mem_addr, output mem_data);
endinterface

// File: rtl/orb_rd_arbiter.sv
// Five-way read arbiter onto one shared word memory with MEM_LAT-cycle read latency.
// Fixed priority (bit0 highest) by default; define ORB_ARB_ROUND_ROBIN_EN for round-robin grants.
module orb_rd_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       req_i,
    input  logic [54:0]      rd_addr_i,
    orb_rd_arbiter_if.master mem,
    output logic [59:0]      word_o,
    output logic [4:0]       vld_o,
    output logic [4:0]       ovr_o
);
    localparam logic [1:0] WAIT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOAD} state_t;

    state_t      state_reg;
    logic [1:0]  wait_cnt_reg;
    logic [4:0]  pending_reg;
    logic [11:0] word_reg [5];
    logic [4:0]  rise;
    logic [4:0]  clr;
    logic [10:0] addr_slice [5];
    logic        grant_found;
    logic [2:0]  grant_idx;
`ifdef ORB_ARB_ROUND_ROBIN_EN
    logic [2:0]  ptr_reg;
    int          cand;
`endif

    // Each request level lives on a divided clock: two sync flops, then a rising-edge detect.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_req
            logic [2:0] sync_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sync_reg <= 3'd0;
                else        sync_reg <= {sync_reg[1:0], req_i[gi]};
            end
            assign rise[gi]             = sync_reg[1] & ~sync_reg[2];
            assign addr_slice[gi]       = rd_addr_i[11*gi +: 11];
            assign word_o[12*gi +: 12]  = word_reg[gi];
        end
    endgenerate

    assign clr = (state_reg == LOAD) ? (5'd1 << mem.mem_sel) : 5'd0;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
`ifdef ORB_ARB_ROUND_ROBIN_EN
        cand = 0;
        for (int i = 1; i <= 5; i++) begin
            cand = (int'(ptr_reg) + i) % 5;
            if (!grant_found && pending_reg[3'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(cand);
            end
        end
`else
        for (int i = 4; i >= 0; i--) begin
            if (pending_reg[3'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(i);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 2'd0;
            pending_reg  <= 5'd0;
            mem.mem_rd   <= 1'b0;
            mem.mem_sel  <= 3'd0;
            mem.mem_addr <= 11'd0;
            word_reg     <= '{default: 12'd0};
            vld_o        <= 5'd0;
            ovr_o        <= 5'd0;
`ifdef ORB_ARB_ROUND_ROBIN_EN
            ptr_reg      <= 3'd4;
`endif
        end else begin
            vld_o      <= 5'd0;
            mem.mem_rd <= 1'b0;
            // A fresh edge landing on its own LOAD re-arms the request rather than overrunning.
            pending_reg <= (pending_reg & ~clr) | rise;
            ovr_o       <= ovr_o | (rise & pending_reg & ~clr);
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        mem.mem_sel  <= grant_idx;
                        mem.mem_addr <= addr_slice[grant_idx];
                        mem.mem_rd   <= 1'b1;
                        state_reg    <= ISSUE;
`ifdef ORB_ARB_ROUND_ROBIN_EN
                        ptr_reg      <= grant_idx;
`endif
                    end
                end
                ISSUE: begin
                    wait_cnt_reg <= WAIT_INIT;
                    state_reg    <= (MEM_LAT > 1) ? WAIT : LOAD;
                end
                WAIT: begin
                    if (wait_cnt_reg == 2'd0) state_reg <= LOAD;
                    else                      wait_cnt_reg <= wait_cnt_reg - 2'd1;
                end
                LOAD: begin
                    word_reg[mem.mem_sel] <= mem.mem_data;
                    vld_o[mem.mem_sel]    <= 1'b1;
                    state_reg             <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_orb_rd_arbiter.sv
// Randomised bench for orb_rd_arbiter against a timeline model, plus directed cases with literal expectations.
module tb_orb_rd_arbiter;
    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic [4:0]  req_i, req4;
    logic [54:0] rd_addr_i, rd_addr4;
    logic [59:0] word_o, word4;
    logic [4:0]  vld_o, vld4, ovr_o, ovr4;

    orb_rd_arbiter_if mif();
    orb_rd_arbiter_if mif4();

    orb_rd_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .rd_addr_i(rd_addr_i),
        .mem(mif), .word_o(word_o), .vld_o(vld_o), .ovr_o(ovr_o)
    );

    orb_rd_arbiter #(.MEM_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .req_i(req4), .rd_addr_i(rd_addr4),
        .mem(mif4), .word_o(word4), .vld_o(vld4), .ovr_o(ovr4)
    );

    int n_cmp;
    int n_err;
    logic chk_en;
    logic [11:0] img [2048];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memories: the addressed word is valid only in the cycle exactly LAT after the strobe, noise otherwise.
    initial begin
        int cyc, due;
        logic [10:0] due_addr;
        cyc = 0; due = -1; due_addr = 11'd0;
        mif.mem_data = 12'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == due) mif.mem_data = img[due_addr];
            else            mif.mem_data = 12'($urandom);
            if (mif.mem_rd) begin due = cyc + LAT; due_addr = mif.mem_addr; end
        end
    end

    initial begin
        int cyc, due;
        logic [10:0] due_addr;
        cyc = 0; due = -1; due_addr = 11'd0;
        mif4.mem_data = 12'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == due) mif4.mem_data = img[due_addr];
            else            mif4.mem_data = 12'($urandom);
            if (mif4.mem_rd) begin due = cyc + 4; due_addr = mif4.mem_addr; end
        end
    end

    // Behavioural model: request history, pending/overrun sets, and one grant occupying LAT+2 cycles.
    logic [4:0]  m_h0, m_h1, m_h2, m_pend, m_ovr, m_vld;
    logic        m_rd, m_busy;
    logic [2:0]  m_sel;
    logic [10:0] m_addr;
    logic [59:0] m_word;
    int          m_g, m_age;
`ifdef ORB_ARB_ROUND_ROBIN_EN
    int          m_last;

    function automatic int pick_rr(input logic [4:0] p, input int last);
        for (int i = 1; i <= 5; i++)
            if (p[3'((last + i) % 5)]) return (last + i) % 5;
        return 0;
    endfunction
`else
    function automatic int pick_fixed(input logic [4:0] p);
        for (int i = 0; i < 5; i++)
            if (p[3'(i)]) return i;
        return 0;
    endfunction
`endif

    task automatic model_clear();
        m_h0 = 0; m_h1 = 0; m_h2 = 0; m_pend = 0; m_ovr = 0; m_vld = 0;
        m_rd = 0; m_busy = 0; m_sel = 0; m_addr = 0; m_word = 0; m_g = 0; m_age = 0;
`ifdef ORB_ARB_ROUND_ROBIN_EN
        m_last = 4;
`endif
    endtask

    initial begin
        logic [4:0] rise, clr;
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_clear();
            end else begin
                rise = m_h1 & ~m_h2;
                m_h2 = m_h1; m_h1 = m_h0; m_h0 = req_i;
                clr = 5'd0; m_vld = 5'd0; m_rd = 1'b0;
                if (m_busy) begin
                    m_age++;
                    if (m_age == LAT + 1) begin
                        clr    = 5'd1 << m_g;
                        m_word = (m_word & ~(60'hFFF << (12 * m_g))) | (60'(img[m_addr]) << (12 * m_g));
                        m_vld  = clr;
                        m_busy = 1'b0;
                    end
                end else if (m_pend != 5'd0) begin
`ifdef ORB_ARB_ROUND_ROBIN_EN
                    m_g = pick_rr(m_pend, m_last);
                    m_last = m_g;
`else
                    m_g = pick_fixed(m_pend);
`endif
                    m_busy = 1'b1; m_age = 0; m_rd = 1'b1;
                    m_sel  = 3'(m_g);
                    m_addr = 11'(rd_addr_i >> (11 * m_g));
                end
                m_ovr  = m_ovr | (rise & m_pend & ~clr);
                m_pend = (m_pend & ~clr) | rise;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cyc_mem_rd",   64'(mif.mem_rd),   64'(m_rd));
                check("cyc_mem_sel",  64'(mif.mem_sel),  64'(m_sel));
                check("cyc_mem_addr", 64'(mif.mem_addr), 64'(m_addr));
                check("cyc_word_o",   64'(word_o),       64'(m_word));
                check("cyc_vld_o",    64'(vld_o),        64'(m_vld));
                check("cyc_ovr_o",    64'(ovr_o),        64'(m_ovr));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        req_i = 5'd0; req4 = 5'd0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int cnt0, cnt2, vcnt;
        int pulse_e [5];
        logic found;
        n_cmp = 0; n_err = 0; chk_en = 1'b0;
        reset = 1'b0; req_i = 5'd0; req4 = 5'd0; rd_addr_i = 55'd0; rd_addr4 = 55'd0;
        for (int a = 0; a < 2048; a++) img[11'(a)] = 12'($urandom);
        img[11'h155] = 12'hABC;
        repeat (3) @(negedge clk);
        check("rst_mem_rd",   64'(mif.mem_rd),   64'd0);
        check("rst_mem_sel",  64'(mif.mem_sel),  64'd0);
        check("rst_mem_addr", 64'(mif.mem_addr), 64'd0);
        check("rst_word_o",   64'(word_o),       64'd0);
        check("rst_vld_o",    64'(vld_o),        64'd0);
        check("rst_ovr_o",    64'(ovr_o),        64'd0);
        chk_en = 1'b1;
        reset = 1'b1;

        // MEM_LAT=4 instance: single request on bit3; e counts clock edges after req rises.
        rd_addr4 = 55'd0; rd_addr4[43:33] = 11'h2A5; req4 = 5'b01000;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            if (e == 4) begin
                check("l4_mem_rd",   64'(mif4.mem_rd),   64'd1);
                check("l4_mem_addr", 64'(mif4.mem_addr), 64'h2A5);
                check("l4_mem_sel",  64'(mif4.mem_sel),  64'd3);
            end
            if (e == 5) check("l4_rd_once", 64'(mif4.mem_rd), 64'd0);
            if (e == 8) check("l4_vld_early", 64'(vld4), 64'd0);
            if (e == 9) begin
                check("l4_vld",  64'(vld4),          64'b01000);
                check("l4_word", 64'(word4[47:36]),  64'(img[11'h2A5]));
            end
        end
        check("l4_ovr", 64'(ovr4), 64'd0);
        req4 = 5'd0;

        // Single request: strobe after edge 4, word and vld visible the cycle after LOAD (edge 7).
        do_reset();
        rd_addr_i = 55'({$urandom(), $urandom()});
        rd_addr_i[10:0] = 11'h155; req_i = 5'b00001;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 3) check("s_rd_e3", 64'(mif.mem_rd), 64'd0);
            if (e == 4) begin
                check("s_rd_e4",   64'(mif.mem_rd),   64'd1);
                check("s_addr_e4", 64'(mif.mem_addr), 64'h155);
                check("s_sel_e4",  64'(mif.mem_sel),  64'd0);
            end
            if (e == 5) check("s_rd_e5", 64'(mif.mem_rd), 64'd0);
            if (e == 6) check("s_vld_e6", 64'(vld_o), 64'd0);
            if (e == 7) begin
                check("s_vld_e7",  64'(vld_o),        64'b00001);
                check("s_word_e7", 64'(word_o[11:0]), 64'hABC);
            end
        end
        req_i = 5'd0;

        // Overrun: bit2 pulsed twice 3 cycles apart while bit0 is being served.
        do_reset();
        cnt0 = 0; cnt2 = 0;
        req_i = 5'b00001;
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            cnt0 += int'(vld_o[0]); cnt2 += int'(vld_o[2]);
            if (e == 1 || e == 4) req_i = 5'b00101;
            if (e == 2 || e == 5) req_i = 5'b00001;
        end
        check("ovr_flag", 64'(ovr_o), 64'b00100);
        check("ovr_vld0_count", 64'(cnt0), 64'd1);
        check("ovr_vld2_count", 64'(cnt2), 64'd1);
        req_i = 5'd0;

        // Re-request landing on the edge where LOAD clears the same bit: served twice, no overrun.
        do_reset();
        cnt0 = 0;
        req_i = 5'b00001;
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            cnt0 += int'(vld_o[0]);
            if (e == 3) req_i = 5'b00000;
            if (e == 4) req_i = 5'b00001;
        end
        check("coin_ovr", 64'(ovr_o), 64'd0);
        check("coin_vld0_count", 64'(cnt0), 64'd2);
        req_i = 5'd0;

        // All five at once: order 0..4, pulses 4 cycles apart.
        do_reset();
        for (int k = 0; k < 5; k++) pulse_e[k] = -1;
        rd_addr_i = 55'({$urandom(), $urandom()});
        req_i = 5'b11111;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++)
                if (((vld_o >> k) & 5'd1) != 5'd0 && pulse_e[k] < 0) pulse_e[k] = e;
        end
        for (int k = 0; k < 5; k++) check("all_pulse_edge", 64'(pulse_e[k]), 64'(7 + 4 * k));
        check("all_ovr", 64'(ovr_o), 64'd0);
        req_i = 5'd0;
        repeat (6) @(negedge clk);

        // Reset while the read for bit1 sits in WAIT: everything clears, nothing loads afterwards.
        rd_addr_i[21:11] = 11'h3C3;
        req_i = 5'b00010;
        found = 1'b0;
        for (int e = 1; e <= 12 && !found; e++) begin
            @(negedge clk);
            if (e == 2) req_i = 5'd0;
            if (mif.mem_rd) found = 1'b1;
        end
        check("mid_rd_seen", 64'(found), 64'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("mid_mem_rd",   64'(mif.mem_rd),   64'd0);
        check("mid_mem_sel",  64'(mif.mem_sel),  64'd0);
        check("mid_mem_addr", 64'(mif.mem_addr), 64'd0);
        check("mid_word_o",   64'(word_o),       64'd0);
        check("mid_vld_o",    64'(vld_o),        64'd0);
        check("mid_ovr_o",    64'(ovr_o),        64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        vcnt = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (vld_o != 5'd0) vcnt++;
        end
        check("mid_no_vld_after", 64'(vcnt), 64'd0);

        // Random traffic: sparse toggles, then dense toggles that provoke overruns.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rd_addr_i = 55'({$urandom(), $urandom()});
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) req_i = req_i ^ (5'd1 << b);
        end
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rd_addr_i = 55'({$urandom(), $urandom()});
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 1) == 0) req_i = req_i ^ (5'd1 << b);
        end
        req_i = 5'd0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
